// File: rtl/input_control_param_if.sv
// Port bundle for the field-selection input controller.
//
// Signalling: there is no valid/ready pair. i_ena is a single-cycle
// sampling strobe; i_wr_pulse, i_sel_inc and i_sel_dec are levels that are
// only looked at on cycles where i_ena=1. o_edit, o_sel_val and o_dbg_state
// are registered levels; o_step and o_timeout are one-clock strobes that
// can only be high on the clock following a tick.
interface input_control_param_if #(
    parameter int SEL_W = 2
);
    logic             i_ena;
    logic             i_wr_pulse;
    logic             i_sel_inc;
    logic             i_sel_dec;
    logic             o_edit;
    logic [SEL_W-1:0] o_sel_val;
    logic             o_step;
    logic             o_timeout;
    logic             o_dbg_state;

    modport master (
        output i_ena, i_wr_pulse, i_sel_inc, i_sel_dec,
        input  o_edit, o_sel_val, o_step, o_timeout, o_dbg_state
    );

    modport slave (
        input  i_ena, i_wr_pulse, i_sel_inc, i_sel_dec,
        output o_edit, o_sel_val, o_step, o_timeout, o_dbg_state
    );
endinterface

// File: rtl/input_control_param.sv
// Field-selection controller: a write edge toggles edit mode, inc/dec step
// the selected field with hold-to-repeat, and an idle timeout leaves edit
// mode. Everything is evaluated only on i_ena ticks.
module input_control_param #(
    parameter int NUM_FIELDS   = 4,
    parameter bit WRAP         = 1'b1,
    parameter int REPEAT_DELAY = 8,
    parameter int REPEAT_RATE  = 2,
    parameter int TIMEOUT      = 64
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input_control_param_if.slave  bus
);
    localparam int SEL_W   = (NUM_FIELDS > 2) ? $clog2(NUM_FIELDS) : 1;
    // The hold count stops at H_MAX; beyond that the rate counter paces repeats.
    localparam int H_MAX_I = 1 + REPEAT_DELAY;
    localparam int H_W     = $clog2(H_MAX_I + 1);
    localparam int R_W     = (REPEAT_RATE > 1) ? $clog2(REPEAT_RATE) : 1;
    localparam int I_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [H_W-1:0]   H_MAX   = H_W'(H_MAX_I);
    localparam logic [H_W-1:0]   H_PRE   = H_W'(H_MAX_I - 1);
    localparam logic [R_W-1:0]   R_LAST  = R_W'(REPEAT_RATE - 1);
    localparam logic [I_W-1:0]   I_LAST  = I_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NUM_FIELDS - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EDIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             step_q, step_d;
    logic             to_q, to_d;
    logic [H_W-1:0]   h_q, h_d;
    logic [R_W-1:0]   rate_q, rate_d;
    logic [I_W-1:0]   idle_q, idle_d;
    logic             wr_s_q, wr_s_d;
    logic             inc_s_q, inc_s_d;
    logic             dec_s_q, dec_s_d;

    logic             wr_rise;
    logic             single;
    logic             dir_change;
    logic             any_in;
    logic             do_step;

    // State register and sampled inputs; reset aborts any edit or hold.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            step_q  <= 1'b0;
            to_q    <= 1'b0;
            h_q     <= '0;
            rate_q  <= '0;
            idle_q  <= '0;
            wr_s_q  <= 1'b0;
            inc_s_q <= 1'b0;
            dec_s_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            step_q  <= step_d;
            to_q    <= to_d;
            h_q     <= h_d;
            rate_q  <= rate_d;
            idle_q  <= idle_d;
            wr_s_q  <= wr_s_d;
            inc_s_q <= inc_s_d;
            dec_s_q <= dec_s_d;
        end
    end

    // Next-state: mode toggle wins over stepping, then hold/repeat and idle timeout.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        step_d     = 1'b0;
        to_d       = 1'b0;
        h_d        = h_q;
        rate_d     = rate_q;
        idle_d     = idle_q;
        wr_s_d     = wr_s_q;
        inc_s_d    = inc_s_q;
        dec_s_d    = dec_s_q;
        wr_rise    = 1'b0;
        single     = 1'b0;
        dir_change = 1'b0;
        any_in     = 1'b0;
        do_step    = 1'b0;

        if (bus.i_ena) begin
            wr_s_d  = bus.i_wr_pulse;
            inc_s_d = bus.i_sel_inc;
            dec_s_d = bus.i_sel_dec;
            wr_rise = bus.i_wr_pulse & ~wr_s_q;
            single  = bus.i_sel_inc ^ bus.i_sel_dec;
            any_in  = bus.i_wr_pulse | bus.i_sel_inc | bus.i_sel_dec;
            // A nonzero hold count means the previous tick was a counted
            // single-direction tick, so its samples give the held direction.
            dir_change = (h_q != '0) &&
                         ((bus.i_sel_inc != inc_s_q) || (bus.i_sel_dec != dec_s_q));

            unique case (state_q)
                ST_IDLE: begin
                    h_d    = '0;
                    rate_d = '0;
                    idle_d = '0;
                    if (wr_rise) begin
                        state_d = ST_EDIT;
                    end
                end
                ST_EDIT: begin
                    if (wr_rise) begin
                        state_d = ST_IDLE;
                        h_d     = '0;
                        rate_d  = '0;
                        idle_d  = '0;
                    end else begin
                        if (!single || dir_change) begin
                            h_d    = '0;
                            rate_d = '0;
                        end else if (h_q == H_MAX) begin
                            if (rate_q == R_LAST) begin
                                rate_d  = '0;
                                do_step = 1'b1;
                            end else begin
                                rate_d = rate_q + R_W'(1);
                            end
                        end else begin
                            h_d     = h_q + H_W'(1);
                            rate_d  = '0;
                            do_step = (h_q == '0) || (h_q == H_PRE);
                        end

                        if (any_in) begin
                            idle_d = '0;
                        end else if (TIMEOUT > 0) begin
                            if (idle_q == I_LAST) begin
                                state_d = ST_IDLE;
                                to_d    = 1'b1;
                                idle_d  = '0;
                                h_d     = '0;
                                rate_d  = '0;
                            end else begin
                                idle_d = idle_q + I_W'(1);
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // Apply a step; a blocked step at a saturating end is silent.
            if (do_step) begin
                if (bus.i_sel_inc) begin
                    if (sel_q == SEL_MAX) begin
                        if (WRAP) begin
                            sel_d  = '0;
                            step_d = 1'b1;
                        end
                    end else begin
                        sel_d  = sel_q + SEL_W'(1);
                        step_d = 1'b1;
                    end
                end else begin
                    if (sel_q == '0) begin
                        if (WRAP) begin
                            sel_d  = SEL_MAX;
                            step_d = 1'b1;
                        end
                    end else begin
                        sel_d  = sel_q - SEL_W'(1);
                        step_d = 1'b1;
                    end
                end
            end
        end
    end

    assign bus.o_edit      = (state_q == ST_EDIT);
    assign bus.o_dbg_state = state_q;
    assign bus.o_sel_val   = sel_q;
    assign bus.o_step      = step_q;
    assign bus.o_timeout   = to_q;
endmodule

// File: doc/input_control_param.md
INPUT_CONTROL_PARAM -- requirements
Module: input_control_param

Interface
REQ-001 SHALL have parameter NUM_FIELDS, default 4: number of selectable fields, legal range 2..256.
REQ-002 SHALL have parameter WRAP, default 1: 1 = selection wraps at the ends, 0 = selection saturates.
REQ-003 SHALL have parameter REPEAT_DELAY, default 8: enable ticks a held inc/dec must persist after its first step before auto-repeat starts (legal >= 1).
REQ-004 SHALL have parameter REPEAT_RATE, default 2: enable ticks between auto-repeat steps (legal >= 1).
REQ-005 SHALL have parameter TIMEOUT, default 64: idle enable ticks in edit mode before automatic exit; 0 disables timeout.
REQ-006 SHALL have local width SEL_W = max(1, clog2(NUM_FIELDS)).
REQ-007 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-008 i_reset_n  input  1  asynchronous, active-low reset.
REQ-009 i_ena  input  1  one-cycle sampling strobe; inputs are evaluated only on cycles with i_ena=1 ("tick").
REQ-010 i_wr_pulse  input  1  edit-mode request level, sampled on ticks.
REQ-011 i_sel_inc  input  1  increment-selection level (may be held), sampled on ticks.
REQ-012 i_sel_dec  input  1  decrement-selection level (may be held), sampled on ticks.
REQ-013 o_edit  output  1  1 = edit mode active (successor of the write toggle).
REQ-014 o_sel_val  output  SEL_W  current selected field, 0..NUM_FIELDS-1.
REQ-015 o_step  output  1  one-clock strobe on the cycle o_sel_val changes.
REQ-016 o_timeout  output  1  one-clock strobe when edit mode exits due to timeout.

Function
REQ-017 All outputs SHALL be registered and update on the rising edge at which i_ena=1; latency is one clock from the tick.
REQ-018 On non-tick cycles, state SHALL hold and o_step/o_timeout SHALL be 0.
REQ-019 The block SHALL keep previous-tick samples of each input; a rising edge is sample=1 with previous sample=0.
REQ-020 States: IDLE (o_edit=0), EDIT (o_edit=1); a wr rising edge SHALL toggle IDLE<->EDIT.
REQ-021 In IDLE, inc/dec SHALL be ignored and o_sel_val SHALL hold; o_sel_val SHALL be retained across EDIT entry and exit.
REQ-022 In EDIT, hold count h SHALL count consecutive ticks with exactly one of inc/dec high (h=1 on the first such tick), saturating internally.
REQ-023 A step SHALL occur at h=1, at h=1+REPEAT_DELAY, and at every further REPEAT_RATE ticks thereafter.
REQ-024 A step SHALL add +1 for inc and -1 for dec.
REQ-025 With WRAP=1, NUM_FIELDS-1 +1 SHALL give 0 and 0 -1 SHALL give NUM_FIELDS-1, including for non-power-of-two NUM_FIELDS.
REQ-026 With WRAP=0, o_sel_val SHALL saturate at 0 and at NUM_FIELDS-1, and o_step SHALL NOT assert on a blocked step.
REQ-027 When inc and dec are both high, or a direction changes, h SHALL be cleared, no step SHALL occur, and counting SHALL restart from h=1 on the next single-direction tick.
REQ-028 A wr rising edge and a step on the same tick: the mode toggle SHALL win, no step SHALL occur, and h SHALL be cleared.
REQ-029 Idle counter: in EDIT, ticks with wr, inc and dec all 0 SHALL increment it; any high input SHALL clear it.
REQ-030 When the idle counter reaches TIMEOUT (TIMEOUT>0), the block SHALL go to IDLE, assert o_timeout for one clock, and clear the counter.
REQ-031 On entering EDIT, the idle counter and h SHALL be cleared.

Reset
REQ-032 i_reset_n=0 SHALL asynchronously force IDLE, o_sel_val=0, o_step=0, o_timeout=0, h=0, idle counter=0, and input samples=0.
REQ-033 Reset asserted mid-hold or mid-edit SHALL abort the operation; after release, a still-held input SHALL count as a fresh rising edge.

Verification
REQ-034 Reset, then wr high for 1 tick -> o_edit=1; a second wr edge -> o_edit=0; o_sel_val=0 throughout.
REQ-035 EDIT, inc pulsed 5 single ticks (defaults) -> o_sel_val 1,2,3,0,1 with 5 o_step strobes; then 5 dec pulses -> 0,3,2,1,0.
REQ-036 EDIT, sel=0, inc held 12 ticks -> steps at h=1,9,11, final o_sel_val=3; inc+dec both high -> no change.
REQ-037 WRAP=0, NUM_FIELDS=5: inc held 20 ticks from 0 -> o_sel_val stops at 4 with no o_step at the limit; dec at 0 -> stays 0.
REQ-038 EDIT with no input for 64 ticks -> o_edit=0 and a single o_timeout strobe on the 64th tick; with TIMEOUT=0 -> o_edit stays 1.
REQ-039 IDLE, inc held -> no change; reset pulsed during an EDIT hold -> all outputs 0 immediately, without waiting for a clock.
